// File: rtl/frame_capture_writer_if.sv
//------------------------------------------------------------------------------
// Module   : frame_capture_writer_if
// Purpose  : Camera byte bus in, BRAM write port out, for frame_capture_writer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface frame_capture_writer_if #(
  parameter int ADDR_W = 18
);
  logic              pclk_en;
  logic              vsync;
  logic              href;
  logic [7:0]        cam_d;
  logic [ADDR_W-1:0] addr;
  logic [11:0]       din;
  logic              we;

  modport master (
    output pclk_en, vsync, href, cam_d,
    input  addr, din, we
  );

  modport slave (
    input  pclk_en, vsync, href, cam_d,
    output addr, din, we
  );
endinterface

`default_nettype wire

// File: rtl/frame_capture_writer.sv
//------------------------------------------------------------------------------
// Module   : frame_capture_writer
// Purpose  : Assembles camera byte pairs into RGB444 pixels and writes them to
//            the frame buffer, framed on vsync, with per-frame count/status.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_capture_writer #(
  parameter int PIXELS = 153600,
  parameter int ADDR_W = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_capture_writer_if.slave bus,
  input  logic                  capture_en,
  output logic                  frame_done,
  output logic [ADDR_W-1:0]     frame_pixels,
  output logic                  frame_error,
  output logic                  busy
);

  // One extra bit so the pointer can hold PIXELS even when PIXELS == 2**ADDR_W.
  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] C_PIXELS = CNT_W'(PIXELS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_VBLANK  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [3:0]        red_q, red_d;
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       din_q, din_d;
  logic              we_q, we_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] frame_pixels_q, frame_pixels_d;
  logic              frame_error_q, frame_error_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      phase_q        <= 1'b0;
      red_q          <= 4'd0;
      wr_ptr_q       <= '0;
      overflow_q     <= 1'b0;
      addr_q         <= '0;
      din_q          <= 12'd0;
      we_q           <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_pixels_q <= '0;
      frame_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      red_q          <= red_d;
      wr_ptr_q       <= wr_ptr_d;
      overflow_q     <= overflow_d;
      addr_q         <= addr_d;
      din_q          <= din_d;
      we_q           <= we_d;
      frame_done_q   <= frame_done_d;
      frame_pixels_q <= frame_pixels_d;
      frame_error_q  <= frame_error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    red_d          = red_q;
    wr_ptr_d       = wr_ptr_q;
    overflow_d     = overflow_q;
    addr_d         = addr_q;
    din_d          = din_q;
    we_d           = 1'b0;
    frame_done_d   = 1'b0;
    frame_pixels_d = frame_pixels_q;
    frame_error_d  = frame_error_q;

    if (bus.pclk_en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.vsync) state_d = S_VBLANK;
        end
        S_VBLANK: begin
          if (!bus.vsync) begin
            if (capture_en) begin
              wr_ptr_d   = '0;
              phase_d    = 1'b0;
              overflow_d = 1'b0;
              state_d    = S_CAPTURE;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_CAPTURE: begin
          // vsync has priority over href: the coincident byte is dropped.
          if (bus.vsync) begin
            frame_done_d   = 1'b1;
            frame_pixels_d = wr_ptr_q[ADDR_W-1:0];
            frame_error_d  = (wr_ptr_q != C_PIXELS) | overflow_q;
            phase_d        = 1'b0;
            state_d        = S_VBLANK;
          end else if (bus.href) begin
            if (!phase_q) begin
              red_d   = bus.cam_d[3:0];
              phase_d = 1'b1;
            end else begin
              if (wr_ptr_q < C_PIXELS) begin
                we_d     = 1'b1;
                addr_d   = wr_ptr_q[ADDR_W-1:0];
                din_d    = {red_q, bus.cam_d};
                wr_ptr_d = wr_ptr_q + 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
              phase_d = 1'b0;
            end
          end else begin
            phase_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.addr     = addr_q;
  assign bus.din      = din_q;
  assign bus.we       = we_q;
  assign frame_done   = frame_done_q;
  assign frame_pixels = frame_pixels_q;
  assign frame_error  = frame_error_q;
  assign busy         = (state_q == S_CAPTURE);

endmodule

`default_nettype wire

// File: tb/tb_frame_capture_writer.sv
//------------------------------------------------------------------------------
// Module   : tb_frame_capture_writer
// Purpose  : Directed scoreboard bench for frame_capture_writer (small frame).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_frame_capture_writer;

  localparam int PIX = 48;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          capture_en;
  logic          frame_done;
  logic [AW-1:0] frame_pixels;
  logic          frame_error;
  logic          busy;

  frame_capture_writer_if #(.ADDR_W(AW)) bus_if ();

  frame_capture_writer #(
    .PIXELS (PIX),
    .ADDR_W (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_if),
    .capture_en   (capture_en),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .frame_error  (frame_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int             checks    = 0;
  int             errors    = 0;
  int             done_seen = 0;
  int             done_exp  = 0;
  int             exp_ptr   = 0;
  bit             exp_ovf   = 1'b0;
  bit             cap_on    = 1'b0;
  logic [7:0]     bval;
  logic [AW+11:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every BRAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus_if.we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("we_unexpected", {31'd0, bus_if.we}, 32'd0);
      end else begin
        logic [AW+11:0] e;
        e = sb_q.pop_front();
        check("wr_addr", {26'd0, bus_if.addr}, {26'd0, e[AW+11:12]});
        check("wr_din", {20'd0, bus_if.din}, {20'd0, e[11:0]});
      end
    end
    if (frame_done === 1'b1) done_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic v, input logic h, input logic [7:0] d);
    bus_if.pclk_en = 1'b1;
    bus_if.vsync   = v;
    bus_if.href    = h;
    bus_if.cam_d   = d;
    @(posedge clk); #1;
    bus_if.pclk_en = 1'b0;
  endtask

  // Idle cycles with junk on the camera lines; must be ignored.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.pclk_en = 1'b0;
      bus_if.vsync   = 1'($urandom_range(0, 1));
      bus_if.href    = 1'($urandom_range(0, 1));
      bus_if.cam_d   = 8'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic pixel(input logic [7:0] b0, input logic [7:0] b1, input int gap, input bit lat);
    logic wr;
    wr = 1'b0;
    send(1'b0, 1'b1, b0);
    idle(gap);
    if (cap_on) begin
      if (exp_ptr < PIX) begin
        sb_q.push_back({AW'(exp_ptr), b0[3:0], b1});
        exp_ptr++;
        wr = 1'b1;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    send(1'b0, 1'b1, b1);
    if (lat) check("we_latency", {31'd0, bus_if.we}, {31'd0, wr});
    idle(gap);
    if (lat && gap > 0) check("we_one_cycle", {31'd0, bus_if.we}, 32'd0);
  endtask

  task automatic line_break(input int gap);
    send(1'b0, 1'b0, 8'h00);
    idle(gap);
  endtask

  task automatic frame_start(input bit cap, input int gap);
    capture_en = cap;
    send(1'b1, 1'b0, 8'h00); idle(gap);
    send(1'b1, 1'b0, 8'h00); idle(gap);
    send(1'b0, 1'b0, 8'h00);
    cap_on  = cap;
    exp_ptr = 0;
    exp_ovf = 1'b0;
    idle(gap);
    capture_en = ~cap;
  endtask

  task automatic frame_end(input int gap, input logic h);
    send(1'b1, h, 8'hA5);
    if (cap_on) begin
      check("frame_done", {31'd0, frame_done}, 32'd1);
      check("frame_pixels", {26'd0, frame_pixels}, {26'd0, AW'(exp_ptr)});
      check("frame_error", {31'd0, frame_error}, {31'd0, ((exp_ptr != PIX) || exp_ovf)});
      done_exp++;
    end else begin
      check("no_frame_done", {31'd0, frame_done}, 32'd0);
    end
    cap_on = 1'b0;
    idle(1 + gap);
    check("frame_done_pulse", {31'd0, frame_done}, 32'd0);
    check("busy_after_frame", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, {31'd0, bus_if.we}, 32'd0);
    check({tag, "_addr"}, {26'd0, bus_if.addr}, 32'd0);
    check({tag, "_din"}, {20'd0, bus_if.din}, 32'd0);
    check({tag, "_done"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_pixels"}, {26'd0, frame_pixels}, 32'd0);
    check({tag, "_error"}, {31'd0, frame_error}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    capture_en     = 1'b0;
    bus_if.pclk_en = 1'b0;
    bus_if.vsync   = 1'b0;
    bus_if.href    = 1'b0;
    bus_if.cam_d   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Full frame, incrementing bytes, pclk_en continuous.
    bval = 8'h00;
    frame_start(1'b1, 0);
    check("busy_capture", {31'd0, busy}, 32'd1);
    for (int p = 0; p < PIX; p++) begin
      pixel(bval, bval + 8'd1, 0, 1'b0);
      bval = bval + 8'd2;
      if (p % 8 == 7) line_break(0);
    end
    frame_end(0, 1'b0);

    // Long frame: 10 excess pixels must not wrap.
    frame_start(1'b1, 0);
    for (int p = 0; p < PIX + 10; p++) begin
      pixel(bval, bval ^ 8'h5A, 0, 1'b0);
      bval = bval + 8'd3;
      if (p % 8 == 7) line_break(0);
    end
    frame_end(0, 1'b0);
    check("long_last_addr", {26'd0, bus_if.addr}, 32'(PIX - 1));

    // Short frame with odd trailing bytes; frame ends on an href=1 sample.
    frame_start(1'b1, 0);
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < ((l == 2) ? 6 : 7); p++) begin
        pixel(bval, ~bval, 0, 1'b0);
        bval = bval + 8'd7;
      end
      send(1'b0, 1'b1, 8'hEE);
      line_break(0);
    end
    pixel(8'h12, 8'h34, 0, 1'b0);
    send(1'b0, 1'b1, 8'h9C);
    frame_end(0, 1'b1);

    // Skipped frame, then a normal capture.
    frame_start(1'b0, 0);
    for (int p = 0; p < 10; p++) pixel(8'hC3, 8'h3C, 0, 1'b0);
    frame_end(0, 1'b0);
    frame_start(1'b1, 0);
    for (int p = 0; p < PIX; p++) begin
      pixel(bval, bval + 8'd9, 0, 1'b0);
      bval = bval + 8'd5;
      if (p % 8 == 7) line_break(0);
    end
    frame_end(0, 1'b0);

    // Sparse pclk_en with junk on the bus between strobes.
    frame_start(1'b1, 3);
    for (int p = 0; p < PIX; p++) begin
      pixel(bval, 8'(p), 3, 1'b1);
      bval = bval + 8'd11;
      if (p % 8 == 7) line_break(3);
    end
    frame_end(3, 1'b0);

    // Reset mid-frame; the rest of that frame must be ignored.
    frame_start(1'b1, 0);
    for (int p = 0; p < 20; p++) pixel(bval + 8'(p), 8'(p * 3), 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_values("midrst");
    rst    = 1'b0;
    cap_on = 1'b0;
    capture_en = 1'b1;
    for (int p = 0; p < 28; p++) pixel(8'hF0, 8'(p), 0, 1'b0);
    frame_end(0, 1'b0);
    frame_start(1'b1, 0);
    for (int p = 0; p < PIX; p++) begin
      pixel(8'(p * 5), 8'(p + 100), 0, 1'b0);
      if (p % 8 == 7) line_break(0);
    end
    frame_end(0, 1'b0);

    idle(2);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    check("frame_done_count", 32'(done_seen), 32'(done_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_capture_writer.md
# frame_capture_writer

Camera-side writer for the 12-bit pixel frame buffer: takes the 8-bit camera pixel bus (vsync, href, data) and writes one RGB444 pixel per two bytes into the dual-port BRAM at addresses 0..PIXELS-1. The detection blocks read the same buffer through its read port; this block owns the write port. It frames each capture on vsync, drops partial pixels and excess pixels, and reports per-frame pixel count and error status.

## Interface

- PIXELS, 153600, pixels per frame; number of BRAM words written per frame
- ADDR_W, 18, BRAM address width; must satisfy 2^ADDR_W >= PIXELS

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pclk_en  in  1  one-cycle strobe marking a valid camera byte; vsync, href, cam_d are sampled only when high
- vsync  in  1  camera frame sync; high = vertical blank
- href  in  1  camera line valid
- cam_d  in  8  camera data byte
- capture_en  in  1  arm capture of the next frame; sampled at frame start only
- addr  out  ADDR_W  BRAM write address
- din  out  12  BRAM write data {R[3:0], G[3:0], B[3:0]}
- we  out  1  BRAM write enable, one cycle per pixel
- frame_done  out  1  one-cycle pulse at end of each captured frame
- frame_pixels  out  ADDR_W  pixels written in last completed frame, held until next frame_done
- frame_error  out  1  last completed frame had count != PIXELS, held until next frame_done
- busy  out  1  high while in CAPTURE

## Operation

- All input evaluation is qualified by pclk_en; with pclk_en low no state, phase, or counter changes.
- States:
  - IDLE: after reset. On sampled vsync=1, go to VBLANK.
  - VBLANK: on sampled vsync=0 (frame start): if capture_en=1, clear wr_ptr, phase, overflow, then go to CAPTURE. Otherwise go to IDLE, so the frame is skipped and the buffer is left untouched.
  - CAPTURE: byte assembly as below. On sampled vsync=1 (frame end), go to VBLANK:
    - pulse frame_done
    - latch frame_pixels = wr_ptr
    - latch frame_error = (wr_ptr != PIXELS) | overflow
- Byte assembly in CAPTURE, href=1:
  - Phase 0: latch cam_d[3:0] as R; phase becomes 1.
  - Phase 1: form din = {R, cam_d[7:0]}. If wr_ptr < PIXELS, assert we with addr = wr_ptr, then wr_ptr increments. Otherwise set overflow and do not write. Phase becomes 0.
- A sample with href=0 forces phase to 0. An odd trailing byte of a line is discarded with no write.
- If vsync=1 and href=1 on the same sample, vsync wins: the frame ends and the byte is dropped.
- wr_ptr never exceeds PIXELS. Address wrap to 0 inside a frame is forbidden.
- busy = (state == CAPTURE).

## Timing

- Reset values: addr=0, din=0, we=0, frame_done=0, frame_pixels=0, frame_error=0, busy=0, state=IDLE, phase=0.
- Write latency: second byte sampled at edge n gives we=1 with valid addr/din during cycle n+1. we is high for exactly one cycle.
- Minimum byte spacing is one clk (pclk_en may be continuously high). Back-to-back pixels give we every second cycle.
- frame_done goes high in the cycle after the vsync-rising sample. frame_pixels and frame_error update in that same cycle.
- A final pixel and frame end cannot coincide, because the vsync sample drops the byte.
- Reset mid-frame: we is low from the cycle after rst. There is no frame_done, and frame_pixels/frame_error clear to 0. Capture resumes only after a full vsync high→low sequence, never mid-frame.
- capture_en changes mid-frame have no effect on the current frame.

## Test plan

- Full frame, PIXELS=153600, incrementing byte pattern, pclk_en always high. Expect:
  - 153600 writes to addr 0..153599, with din = {byte0[3:0], byte1} per pixel
  - frame_done one cycle after vsync rises
  - frame_pixels=153600, frame_error=0
- Long frame with 10 extra pixels. Expect:
  - exactly 153600 writes, last addr=153599, no wrap
  - frame_pixels=153600, frame_error=1
- Short frame of 1000 pixels plus odd trailing bytes on 3 lines. Expect:
  - 1000 writes, odd bytes produce no write
  - frame_pixels=1000, frame_error=1
- capture_en=0 at frame start. Expect zero writes and no frame_done. With capture_en=1 at the next frame start, capture proceeds normally.
- pclk_en high only every 4th cycle, with vsync and href toggling while pclk_en is low. Expect toggles while pclk_en is low to be ignored, and we to follow each second valid byte by one cycle.
- rst asserted after 500 pixels of a frame. Expect:
  - we low the next cycle, all outputs at reset values
  - remainder of that frame ignored
  - next complete frame captured from addr 0
